axi_req_unpacker: RTL

- Parametrised, buffered successor to the combinational request decoder.
- Accepts packed arbiter request words over valid/ready and queues them in a DEPTH-entry FIFO.
- Expands each request into per-beat AXI addresses (FIXED/INCR/WRAP), one beat per handshake.
- Splits every beat address into cache tag/index/offset for the cache lookup stage.

---
 rtl/axi_req_unpacker.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_req_unpacker.sv
// axi_req_unpacker: queues packed arbiter requests in a small FIFO and expands
// each one into per-beat AXI addresses (FIXED/INCR/WRAP), split into cache
// tag/index/offset fields. Optional protocol checking is compiled in when the
// macro AXI_REQ_ERR_CHECK_EN is defined; otherwise beat_err is tied low.
module axi_req_unpacker #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ID_W     = 4,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 3,
  parameter int DEPTH    = 4,
  localparam int STRB_W  = DATA_W / 8,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
  localparam int REQ_W   = 1 + ADDR_W + ID_W + 2 + 3 + 8 + DATA_W + STRB_W,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REQ_W-1:0]    in_req,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic                beat_rw,
  output logic [ID_W-1:0]     beat_id,
  output logic [ADDR_W-1:0]   beat_addr,
  output logic [TAG_W-1:0]    beat_tag,
  output logic [INDEX_W-1:0]  beat_index,
  output logic [OFFSET_W-1:0] beat_offset,
  output logic [2:0]          beat_size,
  output logic [7:0]          beat_num,
  output logic                beat_last,
  output logic [DATA_W-1:0]   beat_wdata,
  output logic [STRB_W-1:0]   beat_wstrb,
  output logic                beat_err,
  output logic                busy,
  output logic [CNT_W-1:0]    fifo_count
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int WDATA_LSB = STRB_W;
  localparam int LEN_LSB   = WDATA_LSB + DATA_W;
  localparam int SIZE_LSB  = LEN_LSB + 8;
  localparam int BURST_LSB = SIZE_LSB + 3;
  localparam int ID_LSB    = BURST_LSB + 2;
  localparam int ADDR_LSB  = ID_LSB + ID_W;
  localparam int RW_BIT    = ADDR_LSB + ADDR_W;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nx;

  logic [REQ_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, load, adv;

  // Head-of-FIFO fields, unpacked (stage 0)
  logic [REQ_W-1:0]  head_p0;
  logic              rw_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ID_W-1:0]   id_p0;
  logic [1:0]        burst_p0;
  logic [2:0]        size_p0;
  logic [7:0]        len_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [STRB_W-1:0] wstrb_p0;

  // Registered beat state (stage 1)
  logic              vld_p1;
  logic              rw_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ID_W-1:0]   id_p1;
  logic [1:0]        burst_p1;
  logic [2:0]        size_p1;
  logic [7:0]        len_p1;
  logic [7:0]        num_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [STRB_W-1:0] wstrb_p1;
  logic              last_p1;

  // Address of the following beat for the given burst type.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        b,
                                                  input logic [2:0]        s,
                                                  input logic [7:0]        l);
    logic [ADDR_W-1:0] inc, wb, r;
    inc = ADDR_W'(1) << s;
    wb  = (ADDR_W'(l) + ADDR_W'(1)) << s;
    case (b)
      2'b00:   r = a;
      2'b10:   r = (a & ~(wb - ADDR_W'(1))) | ((a + inc) & (wb - ADDR_W'(1)));
      default: r = (a & ~(inc - ADDR_W'(1))) + inc;
    endcase
    return r;
  endfunction

  assign head_p0  = mem[rd_ptr];
  assign rw_p0    = head_p0[RW_BIT];
  assign addr_p0  = head_p0[ADDR_LSB +: ADDR_W];
  assign id_p0    = head_p0[ID_LSB +: ID_W];
  assign burst_p0 = head_p0[BURST_LSB +: 2];
  assign size_p0  = head_p0[SIZE_LSB +: 3];
  assign len_p0   = head_p0[LEN_LSB +: 8];
  assign wdata_p0 = head_p0[WDATA_LSB +: DATA_W];
  assign wstrb_p0 = head_p0[0 +: STRB_W];

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign vld_p1   = (state == BURST);
  assign last_p1  = (num_p1 == len_p1);

  // FIFO storage; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state: load from FIFO when idle or on the last beat, else advance
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          load     = 1'b1;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (beat_ready) begin
          if (!last_p1) begin
            adv = 1'b1;
          end else if (count != '0) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat register: load a fresh request or step to the next beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_p1    <= 1'b0;
      addr_p1  <= '0;
      id_p1    <= '0;
      burst_p1 <= '0;
      size_p1  <= '0;
      len_p1   <= '0;
      num_p1   <= '0;
      wdata_p1 <= '0;
      wstrb_p1 <= '0;
    end else if (load) begin
      rw_p1    <= rw_p0;
      addr_p1  <= addr_p0;
      id_p1    <= id_p0;
      burst_p1 <= burst_p0;
      size_p1  <= size_p0;
      len_p1   <= len_p0;
      num_p1   <= '0;
      wdata_p1 <= wdata_p0;
      wstrb_p1 <= wstrb_p0;
    end else if (adv) begin
      addr_p1  <= next_addr(addr_p1, burst_p1, size_p1, len_p1);
      num_p1   <= num_p1 + 8'd1;
    end
  end

`ifdef AXI_REQ_ERR_CHECK_EN
  localparam int MAX_SIZE = $clog2(STRB_W);

  logic err_p1;

  // Protocol violations of one request; only the low 12 address bits matter.
  function automatic logic req_err(input logic [11:0] a,
                                   input logic [1:0]  b,
                                   input logic [2:0]  s,
                                   input logic [7:0]  l);
    logic [16:0] span;
    logic [11:0] mask;
    logic        e;
    span = 17'(a) + ((17'(l) + 17'd1) << s);
    mask = (12'd1 << s) - 12'd1;
    e    = 1'b0;
    if (int'(s) > MAX_SIZE) e = 1'b1;
    if (b == 2'b11) e = 1'b1;
    if (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) e = 1'b1;
    if (b == 2'b10 && (a & mask) != 12'd0) e = 1'b1;
    if (b == 2'b01 && span > 17'd4096) e = 1'b1;
    return e;
  endfunction

  // Error flag captured once per request and held across its beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_p1 <= 1'b0;
    else if (load) err_p1 <= req_err(addr_p0[11:0], burst_p0, size_p0, len_p0);
  end

  assign beat_err = vld_p1 & err_p1;
`else
  assign beat_err = 1'b0;
`endif

  assign beat_valid  = vld_p1;
  assign beat_rw     = rw_p1;
  assign beat_id     = id_p1;
  assign beat_addr   = addr_p1;
  assign beat_tag    = addr_p1[ADDR_W-1 -: TAG_W];
  assign beat_index  = addr_p1[OFFSET_W +: INDEX_W];
  assign beat_offset = addr_p1[OFFSET_W-1:0];
  assign beat_size   = size_p1;
  assign beat_num    = num_p1;
  assign beat_last   = vld_p1 & last_p1;
  assign beat_wdata  = wdata_p1;
  assign beat_wstrb  = wstrb_p1;
  assign busy        = (count != '0) | vld_p1;
  assign fifo_count  = count;

endmodule
